// File: rtl/sd_host_regbank.sv
// SD host controller register bank: CPU req/ack access, hardware update
// port, read-only masking, W1C interrupt status with enables, soft reset.
module sd_host_regbank #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 5,
    parameter int                    NUM_REGS      = 28,
    parameter logic [NUM_REGS-1:0]   RO_MASK       = 28'h00F00F0,
    parameter int                    INT_STAT_ADDR = 12,
    parameter int                    INT_STEN_ADDR = 13,
    parameter int                    INT_SGEN_ADDR = 14,
    parameter int                    SRST_ADDR     = 11,
    parameter int                    SRST_BIT      = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req,
    input  logic                           rw,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           ack,
    output logic                           addr_err,
    input  logic                           hw_we,
    input  logic [ADDR_WIDTH-1:0]          hw_addr,
    input  logic [DATA_WIDTH-1:0]          hw_data,
    input  logic [DATA_WIDTH-1:0]          evt_set,
    output logic                           irq,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] NREG = (ADDR_WIDTH+1)'(NUM_REGS);

    state_t                state;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] nxt  [NUM_REGS];

    logic                  accept;
    logic                  in_range;
    logic                  ro;
    logic                  cpu_wr;
    logic                  srst_hit;
    logic [DATA_WIDTH-1:0] rd_val;

    assign accept   = (state == IDLE) && req;
    assign in_range = {1'b0, addr} < NREG;
    assign ro       = in_range && RO_MASK[addr];
    assign cpu_wr   = accept && !rw && in_range && !ro;
    assign srst_hit = cpu_wr && (addr == ADDR_WIDTH'(SRST_ADDR))
                      && data_in[SRST_BIT];
    assign rd_val   = in_range ? regs[addr] : '0;

    // Priority, lowest first: CPU write/soft reset, hw write, event set.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            nxt[i] = regs[i];
            if (srst_hit && !RO_MASK[i]) begin
                nxt[i] = '0;
            end else if (cpu_wr && addr == ADDR_WIDTH'(i)) begin
                if (i == INT_STAT_ADDR)
                    nxt[i] = regs[i] & ~data_in;
                else
                    nxt[i] = data_in;
            end
            if (hw_we && hw_addr == ADDR_WIDTH'(i))
                nxt[i] = hw_data;
            if (i == INT_STAT_ADDR)
                nxt[i] = nxt[i] | (evt_set & regs[INT_STEN_ADDR]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= nxt[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(regs[INT_STAT_ADDR] & regs[INT_SGEN_ADDR]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ack      <= 1'b0;
            addr_err <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        state    <= ACK;
                        ack      <= 1'b1;
                        addr_err <= !in_range || (!rw && ro);
                        if (rw)
                            data_out <= rd_val;
                    end
                end
                ACK: begin
                    ack   <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    ack <= 1'b0;
                    if (!req)
                        state <= IDLE;
                end
                default: begin
                    ack   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++)
            regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_sd_host_regbank.sv
// Directed bench for sd_host_regbank: handshake, RO masking, hw port,
// interrupt status/enables, soft reset, out-of-range and mid-access reset.
module tb_sd_host_regbank;

    logic        clk;
    logic        reset;
    logic        req;
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic        addr_err;
    logic        hw_we;
    logic [4:0]  hw_addr;
    logic [31:0] hw_data;
    logic [31:0] evt_set;
    logic        irq;
    logic [28*32-1:0] regs_flat;

    int total;
    int bad;

    sd_host_regbank dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rw        (rw),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .ack       (ack),
        .addr_err  (addr_err),
        .hw_we     (hw_we),
        .hw_addr   (hw_addr),
        .hw_data   (hw_data),
        .evt_set   (evt_set),
        .irq       (irq),
        .regs_flat (regs_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] reg_at(input int i);
        return regs_flat[i*32 +: 32];
    endfunction

    // Drives one access with req held for hold cycles, counts ack pulses.
    task automatic do_access(input logic r, input logic [4:0] a,
                             input logic [31:0] d, input int hold,
                             output int acks, output logic [31:0] rd,
                             output logic err);
        acks = 0;
        rd = '0;
        err = 1'b0;
        req = 1'b1;
        rw = r;
        addr = a;
        data_in = d;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acks++;
                rd = data_out;
                err = addr_err;
            end
        end
        req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            if (ack)
                acks++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_ack got=%b exp=0", ack);
        end
        total++;
        if (addr_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b exp=0", addr_err);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        total++;
        if (data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_dout got=%h exp=0", data_out);
        end
        total++;
        if (regs_flat !== '0) begin
            bad++;
            $display("FAIL reset_regs got nonzero exp=0");
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rw();
        int n;
        logic [31:0] rd;
        logic e;
        do_access(1'b0, 5'd2, 32'hDEADBEEF, 5, n, rd, e);
        total++;
        if (n !== 1 || e !== 1'b0) begin
            bad++;
            $display("FAIL wr_ack acks=%0d err=%b exp 1/0", n, e);
        end
        do_access(1'b1, 5'd2, 32'h0, 2, n, rd, e);
        total++;
        if (n !== 1 || e !== 1'b0) begin
            bad++;
            $display("FAIL rd_ack acks=%0d err=%b exp 1/0", n, e);
        end
        total++;
        if (rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_data got=%h exp=deadbeef", rd);
        end
    endtask

    task automatic test_ro_hw();
        int n;
        logic [31:0] rd;
        logic e;
        do_access(1'b0, 5'd4, 32'h12345678, 2, n, rd, e);
        total++;
        if (n !== 1 || e !== 1'b1) begin
            bad++;
            $display("FAIL ro_wr acks=%0d err=%b exp 1/1", n, e);
        end
        total++;
        if (reg_at(4) !== 32'h0) begin
            bad++;
            $display("FAIL ro_keep got=%h exp=0", reg_at(4));
        end
        hw_we = 1'b1;
        hw_addr = 5'd4;
        hw_data = 32'h0000ABCD;
        @(posedge clk);
        #1;
        hw_we = 1'b0;
        do_access(1'b1, 5'd4, 32'h0, 2, n, rd, e);
        total++;
        if (rd !== 32'h0000ABCD || e !== 1'b0) begin
            bad++;
            $display("FAIL hw_rd got=%h err=%b exp=0000abcd/0", rd, e);
        end
        // hw beats CPU on the same register in the same cycle
        req = 1'b1;
        rw = 1'b0;
        addr = 5'd3;
        data_in = 32'h1111;
        hw_we = 1'b1;
        hw_addr = 5'd3;
        hw_data = 32'h2222;
        @(posedge clk);
        #1;
        hw_we = 1'b0;
        req = 1'b0;
        total++;
        if (reg_at(3) !== 32'h2222) begin
            bad++;
            $display("FAIL hw_prio got=%h exp=2222", reg_at(3));
        end
        repeat (2) @(posedge clk);
        #1;
        // CPU read alongside hw write returns the old value
        req = 1'b1;
        rw = 1'b1;
        addr = 5'd3;
        hw_we = 1'b1;
        hw_addr = 5'd3;
        hw_data = 32'h3333;
        @(posedge clk);
        #1;
        hw_we = 1'b0;
        req = 1'b0;
        total++;
        if (data_out !== 32'h2222 || reg_at(3) !== 32'h3333) begin
            bad++;
            $display("FAIL rd_old got=%h reg=%h exp=2222/3333",
                     data_out, reg_at(3));
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_irq();
        int n;
        logic [31:0] rd;
        logic e;
        do_access(1'b0, 5'd13, 32'h3, 2, n, rd, e);
        do_access(1'b0, 5'd14, 32'h1, 2, n, rd, e);
        evt_set = 32'h7;
        @(posedge clk);
        #1;
        evt_set = 32'h0;
        total++;
        if (reg_at(12) !== 32'h3 || irq !== 1'b0) begin
            bad++;
            $display("FAIL evt_stat got=%h irq=%b exp=3/0", reg_at(12), irq);
        end
        @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set got=%b exp=1", irq);
        end
        req = 1'b1;
        rw = 1'b0;
        addr = 5'd12;
        data_in = 32'h1;
        @(posedge clk);
        #1;
        req = 1'b0;
        total++;
        if (reg_at(12) !== 32'h2 || irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c got=%h irq=%b exp=2/1", reg_at(12), irq);
        end
        @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clr got=%b exp=0", irq);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_w1c_race();
        int n;
        logic [31:0] rd;
        logic e;
        req = 1'b1;
        rw = 1'b0;
        addr = 5'd12;
        data_in = 32'h2;
        evt_set = 32'h2;
        @(posedge clk);
        #1;
        evt_set = 32'h0;
        req = 1'b0;
        total++;
        if (ack !== 1'b1 || reg_at(12) !== 32'h2) begin
            bad++;
            $display("FAIL w1c_race ack=%b stat=%h exp=1/2", ack, reg_at(12));
        end
        repeat (2) @(posedge clk);
        #1;
        do_access(1'b0, 5'd12, 32'h2, 2, n, rd, e);
        total++;
        if (reg_at(12) !== 32'h0) begin
            bad++;
            $display("FAIL w1c_plain got=%h exp=0", reg_at(12));
        end
        evt_set = 32'h4;
        @(posedge clk);
        #1;
        evt_set = 32'h0;
        total++;
        if (reg_at(12) !== 32'h0) begin
            bad++;
            $display("FAIL evt_masked got=%h exp=0", reg_at(12));
        end
    endtask

    task automatic test_srst();
        int n;
        logic [31:0] rd;
        logic e;
        do_access(1'b0, 5'd2, 32'hAAAA5555, 2, n, rd, e);
        do_access(1'b0, 5'd11, 32'h0100_0000, 2, n, rd, e);
        total++;
        if (n !== 1 || e !== 1'b0) begin
            bad++;
            $display("FAIL srst_ack acks=%0d err=%b exp 1/0", n, e);
        end
        do_access(1'b1, 5'd2, 32'h0, 2, n, rd, e);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL srst_r2 got=%h exp=0", rd);
        end
        do_access(1'b1, 5'd11, 32'h0, 2, n, rd, e);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL srst_r11 got=%h exp=0", rd);
        end
        do_access(1'b1, 5'd4, 32'h0, 2, n, rd, e);
        total++;
        if (rd !== 32'h0000ABCD) begin
            bad++;
            $display("FAIL srst_r4 got=%h exp=0000abcd", rd);
        end
        total++;
        if (reg_at(13) !== 32'h0 || reg_at(3) !== 32'h0) begin
            bad++;
            $display("FAIL srst_other r13=%h r3=%h exp=0/0",
                     reg_at(13), reg_at(3));
        end
    endtask

    task automatic test_oob();
        int n;
        logic [31:0] rd;
        logic e;
        do_access(1'b0, 5'd1, 32'h55, 2, n, rd, e);
        do_access(1'b1, 5'd1, 32'h0, 2, n, rd, e);
        do_access(1'b1, 5'd30, 32'h0, 2, n, rd, e);
        total++;
        if (n !== 1 || rd !== 32'h0 || e !== 1'b1) begin
            bad++;
            $display("FAIL oob_rd acks=%0d got=%h err=%b exp 1/0/1", n, rd, e);
        end
        do_access(1'b0, 5'd28, 32'hFFFF, 2, n, rd, e);
        total++;
        if (n !== 1 || e !== 1'b1) begin
            bad++;
            $display("FAIL oob_wr acks=%0d err=%b exp 1/1", n, e);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] rd;
        logic e;
        do_access(1'b0, 5'd0, 32'h1, 2, n, rd, e);
        req = 1'b1;
        rw = 1'b1;
        addr = 5'd0;
        @(posedge clk);
        #1;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL mid_ack got=%b exp=1", ack);
        end
        reset = 1'b1;
        #1;
        total++;
        if (ack !== 1'b0 || regs_flat !== '0) begin
            bad++;
            $display("FAIL mid_reset ack=%b regs0=%h exp 0/0", ack, reg_at(0));
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ack !== 1'b1 || data_out !== 32'h0) begin
            bad++;
            $display("FAIL mid_restart ack=%b dout=%h exp 1/0", ack, data_out);
        end
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        req = 1'b0;
        rw = 1'b0;
        addr = '0;
        data_in = '0;
        hw_we = 1'b0;
        hw_addr = '0;
        hw_data = '0;
        evt_set = '0;
        test_reset();
        test_rw();
        test_ro_hw();
        test_irq();
        test_w1c_race();
        test_srst();
        test_oob();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_host_regbank.md
Name: sd_host_regbank

Overview:
- Parametrised SD host controller register bank; second generation of the CPU-facing register file.
- Adds reset, a single-pulse req/ack handshake, per-register read-only masking, and a hardware update port for response/status registers.
- Adds a write-1-to-clear interrupt status register, gated by status/signal enables, with an irq output.
- Sits between the CPU bus and the command/data engines, which take every register value from the flat output bus.

Parameters:
- DATA_WIDTH, 32, register and bus width in bits.
- ADDR_WIDTH, 5, address width.
- NUM_REGS, 28, implemented registers (addresses 0..NUM_REGS-1); must be <= 2**ADDR_WIDTH.
- RO_MASK, 28'h00F00F0, bit i=1 makes register i CPU-read-only (default: 4-7 responses, 16-19 capabilities); written only through the hw port.
- INT_STAT_ADDR, 12, interrupt status register (W1C).
- INT_STEN_ADDR, 13, interrupt status enable register.
- INT_SGEN_ADDR, 14, interrupt signal enable register.
- SRST_ADDR, 11, register holding the software reset bit.
- SRST_BIT, 24, bit index of software-reset-all within SRST_ADDR.

Ports:
- clk  in  1  system clock; every flop is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  CPU request; held until ack is seen.
- rw  in  1  1=read, 0=write; sampled with req.
- addr  in  ADDR_WIDTH  register index.
- data_in  in  DATA_WIDTH  CPU write data.
- data_out  out  DATA_WIDTH  CPU read data; valid in the ack cycle, held afterwards.
- ack  out  1  one-cycle acknowledge.
- addr_err  out  1  high with ack when addr >= NUM_REGS or a write targets an RO register.
- hw_we  in  1  hardware write strobe.
- hw_addr  in  ADDR_WIDTH  hardware write index.
- hw_data  in  DATA_WIDTH  hardware write data.
- evt_set  in  DATA_WIDTH  per-bit interrupt event pulses.
- irq  out  1  interrupt request.
- regs_flat  out  NUM_REGS*DATA_WIDTH  all registers; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (async): all registers, data_out, ack, addr_err and irq go to 0.
- Handshake, states IDLE -> ACK -> WAIT:
  - IDLE: req=1 accepts the access; transition to ACK.
  - ACK: the access completes on the accept edge; ack=1 for exactly one cycle; transition to WAIT.
  - WAIT: stay until req=0, then go to IDLE.
  - Latency: ack is asserted the cycle after req is first seen high. A req held high produces exactly one access.
- Read: data_out <= regs[addr]. Out-of-range read returns 0 with addr_err=1.
- Write to a writable register: regs[addr] <= data_in.
- Write to an RO or out-of-range register: the register is unchanged; addr_err=1 and ack is still given.
- Write to INT_STAT_ADDR is W1C: stat <= stat & ~data_in.
- Hardware port: hw_we writes any in-range register, including RO ones; out-of-range hw writes are ignored.
- Events: every cycle, stat <= (stat after the CPU/hw effect) | (evt_set & sten). Event bits that are not enabled are dropped, not latched.
- irq is registered: irq <= |(stat & sgen). It goes high the cycle after the status bit sets.
- Software reset:
  - CPU write with bit SRST_BIT=1 at SRST_ADDR clears every non-RO register to 0 on that edge, including the SRST register itself, so the bit self-clears.
  - RO registers, data_out and the handshake FSM are unaffected; ack is still given.
- Same-cycle priority, highest first:
  1. reset
  2. event set on the status register
  3. hw write
  4. CPU write/W1C
  - Consequences:
    - A status bit cleared by the CPU and set by evt_set in the same cycle ends at 1.
    - hw and CPU writing the same register: the hw value wins.
    - A CPU read in the same cycle as a hw write to that address returns the old value.
- Reset mid-transaction: the FSM returns to IDLE with ack=0. A req still high after reset releases starts a new access.
- regs_flat is combinational from the register array, with no extra latency.

Test Plan:
- Write 32'hDEADBEEF to addr 2 with req held 5 cycles, then read addr 2 -> exactly one ack pulse per access; data_out=32'hDEADBEEF; addr_err=0.
- CPU write 32'h12345678 to addr 4 (RO) -> ack=1, addr_err=1, reg 4 unchanged. Then hw_we to addr 4 with 32'h0000ABCD -> CPU read returns 32'h0000ABCD.
- sten=32'h3, sgen=32'h1; evt_set=32'h7 for one cycle -> stat=32'h3, irq=1 the next cycle. W1C with 32'h1 -> stat=32'h2, irq=0 the following cycle.
- W1C 32'h2 to stat in the same cycle as evt_set bit1=1 -> stat bit1 stays 1.
- Load regs 2 and 4 with nonzero values, then write 32'h0100_0000 to addr 11 -> reg 2 and reg 11 read 0; reg 4 is retained.
- Read addr 30 -> data_out=0, addr_err=1. Assert reset during the ACK state -> ack drops to 0 immediately and all registers read 0.
